i2c_bus_monitor: RTL and testbench

Passive receive front end for the I2C address translator. Samples the upstream SCL/SDA lines, synchronises and deglitches them, detects START/repeated-START/STOP, and deserialises each 9-bit slot into a byte plus its ACK bit. It flags which byte is the address byte, so that the downstream translation stage inside `i2c_top_module` can remap the 7-bit address. It never drives the bus.

---
 rtl/i2c_pkg.sv | 12 +
 rtl/i2c_bus_monitor_if.sv | 25 ++
 rtl/i2c_line_filter.sv | 45 ++++
 rtl/i2c_bus_monitor.sv | 119 +++++++++++
 tb/tb_i2c_bus_monitor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C address-translator receive path.
package i2c_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int I2C_SLOT_BITS = 9;
  localparam int I2C_ADDR_BITS = 7;
  localparam int I2C_CNT_W     = 4;
endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bundle of raw bus inputs and decoded monitor outputs.
interface i2c_bus_monitor_if;
  logic       scl_in;
  logic       sda_in;
  logic       start_det;
  logic       stop_det;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_addr;
  logic       ack_bit;
  logic       bus_busy;
  logic       frame_err;

  modport master (
    input  scl_in, sda_in,
    output start_det, stop_det, byte_valid, byte_data,
           byte_is_addr, ack_bit, bus_busy, frame_err
  );

  modport slave (
    output scl_in, sda_in,
    input  start_det, stop_det, byte_valid, byte_data,
           byte_is_addr, ack_bit, bus_busy, frame_err
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one raw bus line; idles high.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_o
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1];

  // cnt_q holds how many consecutive samples already disagreed with the output
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (samp != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1))
        filt_d = samp;
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_o = filt_q;
endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C receive front end: line filtering, START/STOP detection and
// 9-bit slot deserialisation with address-byte flagging.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input logic               clk,
  input logic               rst,
  i2c_bus_monitor_if.master bus
);
  logic [1:0] raw_w, filt_w;
  logic       scl_f, sda_f;

  assign raw_w = {bus.sda_in, bus.scl_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    i2c_line_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_filter (
      .clk   (clk),
      .rst   (rst),
      .line_i(raw_w[gi]),
      .line_o(filt_w[gi])
    );
  end

  assign scl_f = filt_w[0];
  assign sda_f = filt_w[1];

  logic                 scl_d1_q, sda_d1_q;
  state_e               state_q;
  logic [I2C_CNT_W-1:0] bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 samp_q, pend_q;
  logic                 start_det_q, stop_det_q, byte_valid_q, frame_err_q;
  logic [7:0]           byte_data_q;
  logic                 byte_is_addr_q, ack_bit_q, bus_busy_q;

  logic scl_rise, scl_fall, scl_hold, start_ev, stop_ev;

  assign scl_rise = scl_f & ~scl_d1_q;
  assign scl_fall = ~scl_f & scl_d1_q;
  assign scl_hold = scl_f & scl_d1_q;
  assign start_ev = scl_hold & sda_d1_q & ~sda_f;
  assign stop_ev  = scl_hold & ~sda_d1_q & sda_f;

  // Data bits are sampled on SCL rise but only committed on the following
  // fall, so the SCL-high phase that frames a STOP or repeated START does not
  // count as a started slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d1_q       <= 1'b1;
      sda_d1_q       <= 1'b1;
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      samp_q         <= 1'b0;
      pend_q         <= 1'b0;
      start_det_q    <= 1'b0;
      stop_det_q     <= 1'b0;
      byte_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_addr_q <= 1'b0;
      ack_bit_q      <= 1'b1;
      bus_busy_q     <= 1'b0;
    end else begin
      scl_d1_q     <= scl_f;
      sda_d1_q     <= sda_f;
      start_det_q  <= start_ev;
      stop_det_q   <= stop_ev;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (start_ev || stop_ev) begin
        if (state_q != IDLE && bit_cnt_q != '0)
          frame_err_q <= 1'b1;
        bit_cnt_q <= '0;
        pend_q    <= 1'b0;
        if (start_ev) begin
          state_q    <= ADDR;
          bus_busy_q <= 1'b1;
        end else begin
          state_q    <= IDLE;
          bus_busy_q <= 1'b0;
        end
      end else if (state_q != IDLE) begin
        if (scl_rise) begin
          if (bit_cnt_q == I2C_CNT_W'(I2C_SLOT_BITS - 1)) begin
            byte_data_q    <= shift_q;
            ack_bit_q      <= sda_f;
            byte_is_addr_q <= (state_q == ADDR);
            byte_valid_q   <= 1'b1;
            state_q        <= DATA;
            bit_cnt_q      <= '0;
          end else begin
            samp_q <= sda_f;
            pend_q <= 1'b1;
          end
        end else if (scl_fall && pend_q) begin
          shift_q   <= {shift_q[6:0], samp_q};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          pend_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.start_det    = start_det_q;
  assign bus.stop_det     = stop_det_q;
  assign bus.byte_valid   = byte_valid_q;
  assign bus.byte_data    = byte_data_q;
  assign bus.byte_is_addr = byte_is_addr_q;
  assign bus.ack_bit      = ack_bit_q;
  assign bus.bus_busy     = bus_busy_q;
  assign bus.frame_err    = frame_err_q;
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bit-banged I2C frames, pulse counters
// and a byte log checked against hand-computed values.
module tb_i2c_bus_monitor;
  localparam int HP = 40;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  int         n_start, n_stop, n_valid, n_ferr;
  logic [7:0] log_data [16];
  logic       log_addr [16];
  logic       log_ack  [16];

  i2c_bus_monitor_if bus_if ();

  i2c_bus_monitor dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_start = 0;
    n_stop  = 0;
    n_valid = 0;
    n_ferr  = 0;
  end

  always @(negedge clk) begin
    if (bus_if.start_det === 1'b1) n_start <= n_start + 1;
    if (bus_if.stop_det === 1'b1)  n_stop  <= n_stop + 1;
    if (bus_if.frame_err === 1'b1) n_ferr  <= n_ferr + 1;
    if (bus_if.byte_valid === 1'b1) begin
      if (n_valid < 16) begin
        log_data[n_valid] <= bus_if.byte_data;
        log_addr[n_valid] <= bus_if.byte_is_addr;
        log_ack[n_valid]  <= bus_if.ack_bit;
      end
      n_valid <= n_valid + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    bus_if.sda_in = 1'b0;
    w(HP);
    bus_if.scl_in = 1'b0;
    w(HP);
  endtask

  task automatic send_rep_start();
    w(5);
    bus_if.sda_in = 1'b1;
    w(HP);
    bus_if.scl_in = 1'b1;
    w(HP);
    bus_if.sda_in = 1'b0;
    w(HP);
    bus_if.scl_in = 1'b0;
    w(HP);
  endtask

  task automatic send_stop();
    w(5);
    bus_if.sda_in = 1'b0;
    w(HP);
    bus_if.scl_in = 1'b1;
    w(HP);
    bus_if.sda_in = 1'b1;
    w(HP);
  endtask

  task automatic send_bit(input logic b);
    w(5);
    bus_if.sda_in = b;
    w(HP);
    bus_if.scl_in = 1'b1;
    w(HP);
    bus_if.scl_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(ack);
    w(2);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    bus_if.scl_in = 1'b1;
    bus_if.sda_in = 1'b1;
    w(5);
    rst = 1'b0;
    w(1);
    chk("rst_busy", 32'(bus_if.bus_busy), 32'd0);
    chk("rst_data", 32'(bus_if.byte_data), 32'h00);
    chk("rst_ack", 32'(bus_if.ack_bit), 32'd1);
    chk("rst_addr", 32'(bus_if.byte_is_addr), 32'd0);
    chk("rst_pulses", 32'({bus_if.start_det, bus_if.stop_det, bus_if.byte_valid, bus_if.frame_err}), 32'd0);
    w(20);

    // Reset in the middle of a byte, then finish the byte and stop
    send_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    w(2);
    chk("abort_pre_start", 32'(n_start), 32'd1);
    chk("abort_pre_busy", 32'(bus_if.bus_busy), 32'd1);
    rst = 1'b1;
    w(3);
    chk("abort_rst_busy", 32'(bus_if.bus_busy), 32'd0);
    chk("abort_rst_ack", 32'(bus_if.ack_bit), 32'd1);
    rst = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1);
    w(2);
    chk("abort_post_busy", 32'(bus_if.bus_busy), 32'd0);
    send_stop();
    chk("abort_valid", 32'(n_valid), 32'd0);
    chk("abort_stop", 32'(n_stop), 32'd1);
    chk("abort_ferr", 32'(n_ferr), 32'd0);
    chk("abort_idle_busy", 32'(bus_if.bus_busy), 32'd0);
    chk("abort_start", 32'(n_start), 32'd1);
    w(20);

    // Address write followed by two data bytes and STOP
    send_start();
    send_byte(8'h90, 1'b0);
    chk("aw_start", 32'(n_start), 32'd2);
    chk("aw_valid", 32'(n_valid), 32'd1);
    chk("aw_data", 32'(log_data[0]), 32'h90);
    chk("aw_isaddr", 32'(log_addr[0]), 32'd1);
    chk("aw_ack", 32'(log_ack[0]), 32'd0);
    chk("aw_held", 32'(bus_if.byte_data), 32'h90);
    chk("aw_busy", 32'(bus_if.bus_busy), 32'd1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_stop();
    chk("dat_valid", 32'(n_valid), 32'd3);
    chk("dat1_data", 32'(log_data[1]), 32'hA5);
    chk("dat1_isaddr", 32'(log_addr[1]), 32'd0);
    chk("dat1_ack", 32'(log_ack[1]), 32'd0);
    chk("dat2_data", 32'(log_data[2]), 32'h3C);
    chk("dat2_isaddr", 32'(log_addr[2]), 32'd0);
    chk("dat2_ack", 32'(log_ack[2]), 32'd1);
    chk("dat_stop", 32'(n_stop), 32'd2);
    chk("dat_busy", 32'(bus_if.bus_busy), 32'd0);
    chk("dat_ferr", 32'(n_ferr), 32'd0);
    w(20);

    // Repeated START between two address bytes
    send_start();
    send_byte(8'h90, 1'b0);
    send_rep_start();
    chk("rs_start", 32'(n_start), 32'd4);
    chk("rs_busy", 32'(bus_if.bus_busy), 32'd1);
    chk("rs_ferr", 32'(n_ferr), 32'd0);
    send_byte(8'h91, 1'b0);
    chk("rs_valid", 32'(n_valid), 32'd5);
    chk("rs_first_addr", 32'(log_addr[3]), 32'd1);
    chk("rs_data", 32'(log_data[4]), 32'h91);
    chk("rs_isaddr", 32'(log_addr[4]), 32'd1);
    chk("rs_ack", 32'(log_ack[4]), 32'd0);
    send_stop();
    chk("rs_stop", 32'(n_stop), 32'd3);
    w(20);

    // Two-clock SDA glitch while SCL is high must be rejected
    bus_if.sda_in = 1'b0;
    w(2);
    bus_if.sda_in = 1'b1;
    w(30);
    chk("gl_start", 32'(n_start), 32'd4);
    chk("gl_stop", 32'(n_stop), 32'd3);
    chk("gl_busy", 32'(bus_if.bus_busy), 32'd0);

    // STOP after four bits of a data byte
    send_start();
    send_byte(8'h90, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_stop();
    chk("mb_ferr", 32'(n_ferr), 32'd1);
    chk("mb_valid", 32'(n_valid), 32'd6);
    chk("mb_data", 32'(bus_if.byte_data), 32'h90);
    chk("mb_busy", 32'(bus_if.bus_busy), 32'd0);
    chk("mb_stop", 32'(n_stop), 32'd4);
    // Clocking a byte without a START must stay ignored in IDLE
    send_byte(8'hFF, 1'b1);
    chk("mb_idle_valid", 32'(n_valid), 32'd6);
    send_stop();
    chk("mb_idle_ferr", 32'(n_ferr), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
